datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Instruction sequencer that drives the 4-register ALU datapath.
- Accepts 9-bit register-to-register instructions through a valid/ready push port and buffers them in a small FIFO.
- Issues each instruction as a setup cycle followed by a one-cycle write strobe, and latches the datapath Zero flag.
- Sits between a host or test driver and the datapath's wr/ALUControl/addr1/addr2/addr3 inputs.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, ≥2).
- CNT_W, 8, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction push request.
- in_instr  in  9  [8:6] op, [5:4] dst, [3:2] src1, [1:0] src2.
- in_ready  out  1  FIFO can accept this cycle.
- hold  in  1  1 = do not start a new instruction.
- Zero  in  1  datapath ALU zero flag.
- wr  out  1  register-file write strobe to datapath.
- ALUControl  out  3  ALU op to datapath.
- addr1  out  2  source 1 register.
- addr2  out  2  source 2 register.
- addr3  out  2  destination register.
- busy  out  1  instruction in flight or FIFO non-empty.
- done  out  1  one-cycle pulse per retired instruction.
- zero_flag  out  1  Zero sampled at the last ALU instruction's write edge.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst=0, async): FIFO empty; state IDLE; wr=0, ALUControl=000, addr1/2/3=0, done=0, zero_flag=0, retired=0.
- Reset mid-EXEC drops wr immediately. That instruction is not committed and is not counted.
- in_ready = !full, combinational from occupancy.
  - Push is accepted when in_valid && in_ready at the rising edge.
  - When the FIFO is full, a push is refused even if a pop occurs in the same cycle. The freed slot becomes visible the next cycle.
  - The FIFO preserves order. Pointers wrap modulo DEPTH.
- Op encodings:
  - 000 ADD, 001 SUB, 010 AND, 011 XOR.
  - 100–110 are passed through to ALUControl unchanged.
  - 111 is NOP.
- All datapath-facing outputs (wr, ALUControl, addr1/2/3) are registered.
- FSM states:
  - IDLE: if FIFO non-empty and hold=0, pop the head into the instruction register and go to SETUP. Otherwise stay.
  - SETUP: ALUControl=op, addr1=src1, addr2=src2, addr3=dst; wr=0. Next state is EXEC.
  - EXEC: addresses and op held; wr=1 unless op=111 (wr=0).
    - At the edge leaving EXEC: retired+=1 (wraps to 0 at max); done=1 for the following cycle; zero_flag<=Zero if op≠111, unchanged for NOP.
    - Then if FIFO non-empty and hold=0, pop and go to SETUP; else go to IDLE.
- Outputs stay at their last values in IDLE, with wr=0.
- Latency, push accepted at edge E0:
  - E1: pop and enter SETUP.
  - E2: enter EXEC with wr=1.
  - E3: datapath register written; done high during the E3–E4 cycle.
- Back-to-back throughput is one instruction per 2 cycles; wr pulses are never adjacent.
- hold affects only instruction start. An instruction already in SETUP/EXEC completes. Pushes are still accepted while hold=1.
- busy = (state≠IDLE) || !empty.
- Simultaneous push and pop on a non-full FIFO: both occur; occupancy unchanged.

Test Plan:
- Single ADD: push 0x006 (ADD, dst0, src1, src2) into empty FIFO → after E1 addr1=1, addr2=2, addr3=0, ALUControl=000, wr=0; after E2 wr=1; after E3 wr=0, done=1, retired=1, busy=0.
- Back-to-back and full: push 5 instructions on consecutive cycles with hold=1 (DEPTH=4) → first four accepted, in_ready=0 on the fifth. Release hold → wr pulses on alternate cycles; retired=4 and done seen 4 times.
- Zero capture: push 0x0FA (XOR, dst3, src2, src2) with Zero driven 1 during EXEC → zero_flag=1. Then push 0x006 with Zero=0 → zero_flag=0.
- NOP: push 0x1C0 after zero_flag=1 → wr stays 0 through SETUP/EXEC, zero_flag remains 1, retired increments, done pulses once.
- Hold: queue 2 instructions with hold=1 → state IDLE, busy=1, wr=0 for 10 cycles. Drop hold → both retire in order; addr3 sequence matches push order.
- Reset mid-op: assert rst=0 while wr=1 in EXEC → wr=0 immediately, retired=0, zero_flag=0, in_ready=1, busy=0. After release, no stale instruction issues.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// Instruction push port between a host/test driver and the sequencer.
interface datapath_sequencer_if;
    logic       in_valid;
    logic [8:0] in_instr;
    logic       in_ready;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the 4-register ALU datapath.
// Buffers pushed instructions in a small FIFO and issues each one as a
// SETUP cycle followed by an EXEC cycle carrying the write strobe.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | nothing in flight; outputs hold last values, wr=0
// SETUP   | op/addresses presented to datapath, wr=0
// EXEC    | op/addresses held, wr=1 (except NOP); retires on exit
module datapath_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    datapath_sequencer_if.slave  push,
    input  logic                 hold,
    input  logic                 Zero,
    output logic                 wr,
    output logic [2:0]           ALUControl,
    output logic [1:0]           addr1,
    output logic [1:0]           addr2,
    output logic [1:0]           addr3,
    output logic                 busy,
    output logic                 done,
    output logic                 zero_flag,
    output logic [CNT_W-1:0]     retired
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;

    localparam logic [2:0] OP_NOP  = 3'b111;

    logic [1:0]    state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push_fire;
    logic          pop_fire;
    logic [8:0]    head;

    // Occupancy flags; a full FIFO refuses pushes even when popping this cycle.
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push.in_ready = !full;
    assign push_fire = push.in_valid && !full;
    assign pop_fire  = !empty && !hold && ((state == S_IDLE) || (state == S_EXEC));
    assign head      = mem[rd_ptr];
    assign busy      = (state != S_IDLE) || !empty;

    // FIFO storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push_fire)
            mem[wr_ptr] <= push.in_instr;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM; the registered datapath outputs double as the instruction register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wr         <= 1'b0;
            ALUControl <= 3'b000;
            addr1      <= 2'b00;
            addr2      <= 2'b00;
            addr3      <= 2'b00;
            done       <= 1'b0;
            zero_flag  <= 1'b0;
            retired    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    wr <= 1'b0;
                    if (pop_fire) begin
                        ALUControl <= head[8:6];
                        addr3      <= head[5:4];
                        addr1      <= head[3:2];
                        addr2      <= head[1:0];
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wr    <= (ALUControl != OP_NOP);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wr      <= 1'b0;
                    done    <= 1'b1;
                    retired <= retired + CNT_W'(1);
                    if (ALUControl != OP_NOP)
                        zero_flag <= Zero;
                    if (pop_fire) begin
                        ALUControl <= head[8:6];
                        addr3      <= head[5:4];
                        addr1      <= head[3:2];
                        addr2      <= head[1:0];
                        state      <= S_SETUP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    wr    <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed scenarios followed
// by random traffic, all compared against a transaction-level model.
module tb_datapath_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             hold = 1'b0;
    logic             Zero = 1'b0;
    logic             wr;
    logic [2:0]       ALUControl;
    logic [1:0]       addr1;
    logic [1:0]       addr2;
    logic [1:0]       addr3;
    logic             busy;
    logic             done;
    logic             zero_flag;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending queue, the instruction most recently started,
    // and how many cycles it has been in flight (0 = nothing in flight).
    logic [8:0]       m_q[$];
    logic [8:0]       m_cur;
    int               m_age;
    logic             m_done;
    logic [CNT_W-1:0] m_ret;
    logic             m_zf;
    logic             prev_wr;

    datapath_sequencer_if pif();

    datapath_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (pif),
        .hold       (hold),
        .Zero       (Zero),
        .wr         (wr),
        .ALUControl (ALUControl),
        .addr1      (addr1),
        .addr2      (addr2),
        .addr3      (addr3),
        .busy       (busy),
        .done       (done),
        .zero_flag  (zero_flag),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur   = 9'h000;
        m_age   = 0;
        m_done  = 1'b0;
        m_ret   = '0;
        m_zf    = 1'b0;
        prev_wr = 1'b0;
    endtask

    // One clock edge of the sequencer's rules, using the inputs present at that edge.
    task automatic model_step(input logic v, input logic [8:0] ins, input logic h, input logic z);
        bit was_full;
        was_full = (m_q.size() >= DEPTH);
        m_done   = 1'b0;
        if (m_age == 2) begin
            m_ret  = m_ret + 1'b1;
            m_done = 1'b1;
            if (m_cur[8:6] != 3'b111)
                m_zf = z;
            m_age = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end
        if (m_age == 0 && m_q.size() != 0 && !h) begin
            m_cur = m_q.pop_front();
            m_age = 1;
        end
        if (v && !was_full)
            m_q.push_back(ins);
    endtask

    task automatic check_outputs();
        check("wr",        wr,         (m_age == 2) && (m_cur[8:6] != 3'b111));
        check("alu_ctrl",  ALUControl, m_cur[8:6]);
        check("addr1",     addr1,      m_cur[3:2]);
        check("addr2",     addr2,      m_cur[1:0]);
        check("addr3",     addr3,      m_cur[5:4]);
        check("done",      done,       m_done);
        check("zero_flag", zero_flag,  m_zf);
        check("retired",   retired,    m_ret);
        check("in_ready",  pif.in_ready, m_q.size() < DEPTH);
        check("busy",      busy,       (m_age != 0) || (m_q.size() != 0));
        check("wr_adjacent", prev_wr & wr, 1'b0);
        prev_wr = wr;
    endtask

    task automatic cycle(input logic v, input logic [8:0] ins, input logic h, input logic z);
        pif.in_valid = v;
        pif.in_instr = ins;
        hold         = h;
        Zero         = z;
        @(posedge clk);
        model_step(v, ins, h, z);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic random_cycles(input int n, input bit allow_push);
        for (int i = 0; i < n; i++)
            cycle(allow_push && ($urandom_range(0, 1) == 1), 9'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
    endtask

    initial begin
        bit found;
        pif.in_valid = 1'b0;
        pif.in_instr = 9'h000;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Single ADD into an empty FIFO.
        cycle(1'b1, 9'h006, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);

        // Fill past capacity while held, then drain back-to-back.
        for (int i = 0; i < 5; i++) cycle(1'b1, 9'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 9'h000, 1'b0, 1'($urandom));

        // Zero capture, NOP keeps the flag, then an ADD clears it.
        cycle(1'b1, 9'h0FA, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 1'b0, 1'b1);
        cycle(1'b1, 9'h1C0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);
        cycle(1'b1, 9'h006, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);

        // Hold with two queued instructions, then release.
        cycle(1'b1, 9'h010, 1'b1, 1'b0);
        cycle(1'b1, 9'h025, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 9'h000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);

        random_cycles(600, 1'b1);

        // Reset while a write strobe is active.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b1, 9'($urandom_range(0, 9'h1BF)), 1'b0, 1'b0);
            if (wr) found = 1'b1;
        end
        check("rst_wait_for_wr", found, 1'b1);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b0, 9'h000, 1'b0, 1'b0);
        random_cycles(200, 1'b1);
        random_cycles(10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
